// File: rtl/calc_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package calc_pkg;

    localparam int unsigned BcdDigitW = 4;

    typedef enum logic {
        StIdle,
        StShift
    } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import calc_pkg::*;
(
    input  logic [BcdDigitW-1:0] i_digit,
    output logic [BcdDigitW-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BcdDigitW'(5)) begin
            o_digit = i_digit + BcdDigitW'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
module bin_to_bcd
    import calc_pkg::*;
#(
    parameter int unsigned width  = 16,
    parameter int unsigned digits = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [width-1:0]          bin_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [BcdDigitW*digits-1:0] bcd_o,
    output logic                      ovf_o
);

    localparam int unsigned BcdW = BcdDigitW * digits;
    localparam int unsigned CntW = $clog2(width + 1);

    bcd_state_t      r_state, w_state_nxt;
    logic [width-1:0] r_shift, w_shift_nxt;
    logic [BcdW-1:0] r_acc, w_acc_nxt;
    logic            r_ovf, w_ovf_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [BcdW-1:0] r_bcd, w_bcd_nxt;
    logic            r_ovf_out, w_ovf_out_nxt;
    logic            r_done, w_done_nxt;

    logic [BcdW-1:0] w_acc_adj;
    logic [BcdW-1:0] w_acc_shl;
    logic            w_carry;

    for (genvar g = 0; g < digits; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_acc[g*BcdDigitW +: BcdDigitW]),
            .o_digit (w_acc_adj[g*BcdDigitW +: BcdDigitW])
        );
    end

    // Bit leaving the top digit means the value no longer fits in the digits kept.
    assign w_carry   = w_acc_adj[BcdW-1];
    assign w_acc_shl = {w_acc_adj[BcdW-2:0], r_shift[width-1]};

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_acc_nxt     = r_acc;
        w_ovf_nxt     = r_ovf;
        w_cnt_nxt     = r_cnt;
        w_bcd_nxt     = r_bcd;
        w_ovf_out_nxt = r_ovf_out;
        w_done_nxt    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_shift_nxt = bin_i;
                    w_acc_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                    w_cnt_nxt   = CntW'(width);
                    w_state_nxt = StShift;
                end
            end
            StShift: begin
                w_acc_nxt   = w_acc_shl;
                w_shift_nxt = {r_shift[width-2:0], 1'b0};
                w_ovf_nxt   = r_ovf | w_carry;
                w_cnt_nxt   = r_cnt - CntW'(1);
                if (r_cnt == CntW'(1)) begin
                    w_bcd_nxt     = w_acc_shl;
                    w_ovf_out_nxt = r_ovf | w_carry;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf_out <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_acc     <= w_acc_nxt;
            r_ovf     <= w_ovf_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bcd     <= w_bcd_nxt;
            r_ovf_out <= w_ovf_out_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign busy_o = (r_state == StShift);
    assign done_o = r_done;
    assign bcd_o  = r_bcd;
    assign ovf_o  = r_ovf_out;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Scoreboard bench: directed conversions on a 5-digit and a 4-digit converter.
module tb_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin = '0;
    logic        busy, done, ovf;
    logic [19:0] bcd;

    logic        start4 = 1'b0;
    logic [15:0] bin4 = '0;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;

    int checks = 0;
    int errors = 0;

    logic [20:0] exp_q[$];
    logic [16:0] exp4_q[$];

    always #5 clk = ~clk;

    bin_to_bcd dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .bcd_o   (bcd),
        .ovf_o   (ovf)
    );

    bin_to_bcd #(.width(16), .digits(4)) dut4 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start4),
        .bin_i   (bin4),
        .busy_o  (busy4),
        .done_o  (done4),
        .bcd_o   (bcd4),
        .ovf_o   (ovf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitors: pop the expected result whenever a DUT presents done.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("bcd", 32'(bcd), 32'(e[19:0]));
                check("ovf", 32'(ovf), 32'(e[20]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done4) begin
            if (exp4_q.size() == 0) begin
                check("unexpected_done4", 32'(done4), 32'(0));
            end else begin
                logic [16:0] e;
                e = exp4_q.pop_front();
                check("bcd4", 32'(bcd4), 32'(e[15:0]));
                check("ovf4", 32'(ovf4), 32'(e[16]));
            end
        end
    end

    // One conversion; bin is scrambled after acceptance to prove it is not resampled.
    task automatic conv(input logic [15:0] v, input logic [19:0] exp_bcd);
        int  busy_cnt = 0;
        bit  seen = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        exp_q.push_back({1'b0, exp_bcd});
        @(negedge clk);
        start = 1'b0;
        bin   = ~v;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check("done_seen", 32'(seen), 32'(1));
        check("busy_cycles", 32'(busy_cnt), 32'd16);
        check("busy_low_at_done", 32'(busy), 32'(0));
    endtask

    task automatic conv4(input logic [15:0] v, input logic ovf_exp, input logic [15:0] exp_bcd);
        bit seen = 0;
        @(negedge clk);
        start4 = 1'b1;
        bin4   = v;
        exp4_q.push_back({ovf_exp, exp_bcd});
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done4) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("done4_seen", 32'(seen), 32'(1));
    endtask

    initial begin
        bit seen;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_bcd",  32'(bcd),  32'(0));
        check("rst_ovf",  32'(ovf),  32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        conv(16'd12345, 20'h12345);
        conv(16'hFFFF,  20'h65535);
        conv(16'd0,     20'h00000);
        check("bcd_hold", 32'(bcd), 32'(0));

        // start held high, bin changes mid-conversion, second start taken in the done cycle
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd100;
        exp_q.push_back({1'b0, 20'h00100});
        exp_q.push_back({1'b0, 20'h00999});
        repeat (5) @(negedge clk);
        bin = 16'd999;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("b2b_first_done", 32'(seen), 32'(1));
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", 32'(busy), 32'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("b2b_second_done", 32'(seen), 32'(1));
        check("hold_999", 32'(bcd), 32'h00999);

        // Reset in the middle of a conversion
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_bcd",  32'(bcd),  32'(0));
        check("abort_ovf",  32'(ovf),  32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_idle", 32'(busy), 32'(0));
        conv(16'd42, 20'h00042);

        // Four-digit instance: overflow boundary
        conv4(16'd10000, 1'b1, 16'h0000);
        conv4(16'd9999,  1'b0, 16'h9999);
        conv4(16'd12345, 1'b1, 16'h2345);

        repeat (3) @(negedge clk);
        check("queue_empty",  32'(exp_q.size()),  32'(0));
        check("queue4_empty", 32'(exp4_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter width SHALL default to 16 and set the binary input width, matching the ALU 2*width result for an 8-bit ALU.
REQ-003 Parameter digits SHALL default to 5 and set the number of BCD output digits.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 start_i  input  1  request to convert bin_i; sampled only in IDLE.
REQ-007 bin_i  input  width  unsigned binary value (ALU res_o); sampled on the accepting edge only.
REQ-008 busy_o  output  1  high while a conversion is in progress.
REQ-009 done_o  output  1  one-cycle pulse; bcd_o and ovf_o are valid and updated.
REQ-010 bcd_o  output  4*digits  packed BCD result, digit 0 in bits [3:0].
REQ-011 ovf_o  output  1  result exceeded 10^digits-1; bcd_o holds the low digits.

Function
REQ-012 The conversion SHALL use sequential shift-and-add-3 (double dabble), one input bit per clock.
REQ-013 The FSM SHALL have states IDLE and SHIFT.
REQ-014 IDLE with start_i=1: latch bin_i into the shift register, clear the BCD accumulator and ovf flag, load bit counter = width, go to SHIFT.
REQ-015 IDLE with start_i=0: hold all state.
REQ-016 Each SHIFT edge: add 3 to every accumulator digit >=5, shift {accumulator, shift register} left one bit, and decrement the counter.
REQ-017 Any 1 bit shifted out of the top digit SHALL set the internal ovf flag (sticky for the conversion).
REQ-018 On the SHIFT edge where the counter reaches 0: load bcd_o and ovf_o from the final accumulator and flag, set done_o=1, return to IDLE.
REQ-019 done_o SHALL be high for exactly the one cycle following the width-th SHIFT edge, i.e. width edges after the accepting edge.
REQ-020 busy_o SHALL be 1 exactly while the state is SHIFT.
REQ-021 start_i SHALL be ignored while busy_o=1; bin_i changes during SHIFT SHALL NOT affect the result.
REQ-022 start_i=1 in the done_o cycle SHALL be accepted (back-to-back conversions, throughput of one result per width+1 cycles).
REQ-023 bcd_o and ovf_o SHALL hold their last completed values until the next completion.
REQ-024 bin_i=0 SHALL still take the full width cycles and yield bcd_o=0.

Reset
REQ-025 rst_i high SHALL asynchronously force IDLE, counter=0, and busy_o=0, done_o=0, bcd_o=0, ovf_o=0.
REQ-026 Reset mid-conversion SHALL abort without a done_o pulse; the first start_i after release SHALL begin a fresh conversion.

Structure
REQ-027 Package calc_pkg SHALL hold the FSM state enum typedef and the BCD digit width constant (4).
REQ-028 Per-digit add-3 correction SHALL be a combinational sub-module bcd_digit_adj, instantiated digits times by generate.
REQ-029 Counter width SHALL be $clog2(width+1).

Verification
REQ-030 bin_i=16'd12345, start pulse -> after 16 edges done_o=1, bcd_o=20'h12345, ovf_o=0, busy_o high for 16 cycles.
REQ-031 bin_i=16'hFFFF -> bcd_o=20'h65535, ovf_o=0; bin_i=0 -> bcd_o=0 after 16 edges.
REQ-032 start_i held high with bin_i changed from 100 to 999 mid-conversion -> bcd_o=20'h00100, then a second conversion accepted in the done cycle yields 20'h00999.
REQ-033 rst_i asserted at shift 8 of a conversion -> outputs 0 immediately, no done_o; the next start with 42 yields 20'h00042.
REQ-034 digits=4, bin_i=16'd10000 -> ovf_o=1, bcd_o=16'h0000; bin_i=9999 -> ovf_o=0, bcd_o=16'h9999.
